led_blink_sequencer: RTL and testbench

//   Command-driven sequencer for the 2-bit board LED output. Accepts one blink

---
 rtl/led_blink_sequencer.sv | 135 +++++++++++++
 tb/tb_led_blink_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_sequencer.sv
// LED blink sequencer: accepts one blink command at a time over valid/ready and
// plays it out on the 2-bit LED port as alternating ON/OFF phases.
`timescale 1ns / 1ps

module led_blink_sequencer #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned REP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mask,
  input  logic [CNT_W-1:0] cmd_on,
  input  logic [CNT_W-1:0] cmd_off,
  input  logic [REP_W-1:0] cmd_reps,
  input  logic             abort,
  output logic [1:0]       led,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    StIdle,
    StOn,
    StOff
  } state_e;

  localparam logic [CNT_W-1:0] CntZero = '0;
  localparam logic [CNT_W-1:0] CntOne  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [REP_W-1:0] RepZero = '0;
  localparam logic [REP_W-1:0] RepOne  = {{(REP_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mask_q, mask_d;
  logic [CNT_W-1:0] on_q, on_d;
  logic [CNT_W-1:0] off_q, off_d;
  logic [REP_W-1:0] reps_q, reps_d;
  logic             done_q, done_d;
  logic             accept;

  assign cmd_ready = (state_q == StIdle) & ~abort;
  assign accept    = cmd_valid & cmd_ready;

  // Outputs decoded from the registered state; done is its own register.
  assign led  = (state_q == StOn) ? mask_q : 2'b00;
  assign busy = (state_q != StIdle);
  assign done = done_q;

  // Next-state logic: command capture, phase counting, repeat bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    on_d    = on_q;
    off_d   = off_q;
    reps_d  = reps_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          mask_d  = cmd_mask;
          // Zero-length phases are stretched to one cycle so cnt never underflows.
          on_d    = (cmd_on == CntZero) ? CntOne : cmd_on;
          off_d   = (cmd_off == CntZero) ? CntOne : cmd_off;
          reps_d  = cmd_reps;
          cnt_d   = CntZero;
          state_d = StOn;
        end
      end

      StOn: begin
        if (abort) begin
          state_d = StIdle;
          cnt_d   = CntZero;
        end else if (cnt_q == on_q - CntOne) begin
          state_d = StOff;
          cnt_d   = CntZero;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StOff: begin
        if (abort) begin
          state_d = StIdle;
          cnt_d   = CntZero;
        end else if (cnt_q == off_q - CntOne) begin
          cnt_d = CntZero;
          if (reps_q == RepOne) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StOn;
            // A repeat count of zero means run until aborted.
            if (reps_q != RepZero) begin
              reps_d = reps_q - RepOne;
            end
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = CntZero;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= CntZero;
      mask_q  <= 2'b00;
      on_q    <= CntOne;
      off_q   <= CntOne;
      reps_q  <= RepZero;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      on_q    <= on_d;
      off_q   <= off_d;
      reps_q  <= reps_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Scoreboard bench for led_blink_sequencer: the driver pushes the hand-computed
// outputs expected in each cycle; a monitor pops and compares at the falling edge.
`timescale 1ns / 1ps

module tb_led_blink_sequencer;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_mask;
  logic [31:0] cmd_on;
  logic [31:0] cmd_off;
  logic [7:0]  cmd_reps;
  logic        abort;
  logic [1:0]  led;
  logic        busy;
  logic        done;

  led_blink_sequencer #(
    .CNT_W(32),
    .REP_W(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_mask (cmd_mask),
    .cmd_on   (cmd_on),
    .cmd_off  (cmd_off),
    .cmd_reps (cmd_reps),
    .abort    (abort),
    .led      (led),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] led;
    logic       busy;
    logic       done;
    logic       ready;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Staged stimulus, applied just after the next rising edge.
  logic        s_valid, s_abort, s_rst;
  logic [1:0]  s_mask;
  logic [31:0] s_on, s_off;
  logic [7:0]  s_reps;

  // Monitor: one expected entry per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (led !== e.led || busy !== e.busy || done !== e.done || cmd_ready !== e.ready) begin
          errors++;
          $display("FAIL %s: got led=%b busy=%b done=%b ready=%b, expected led=%b busy=%b done=%b ready=%b",
                   e.tag, led, busy, done, cmd_ready, e.led, e.busy, e.done, e.ready);
        end
      end
    end
  end

  task automatic quiet();
    s_valid = 1'b0;
    s_abort = 1'b0;
    s_rst   = 1'b0;
    s_mask  = 2'b00;
    s_on    = 32'd0;
    s_off   = 32'd0;
    s_reps  = 8'd0;
  endtask

  // Apply staged inputs for one cycle and record that cycle's expected outputs.
  task automatic tick(input logic [1:0] eled, input logic ebusy, input logic edone,
                      input logic erdy, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = s_rst;
    cmd_valid = s_valid;
    cmd_mask  = s_mask;
    cmd_on    = s_on;
    cmd_off   = s_off;
    cmd_reps  = s_reps;
    abort     = s_abort;
    e.led   = eled;
    e.busy  = ebusy;
    e.done  = edone;
    e.ready = erdy;
    e.tag   = tag;
    exp_q.push_back(e);
  endtask

  task automatic run(input logic [1:0] eled, input int n, input string tag);
    quiet();
    repeat (n) tick(eled, 1'b1, 1'b0, 1'b0, tag);
  endtask

  task automatic idle(input logic edone, input string tag);
    quiet();
    tick(2'b00, 1'b0, edone, 1'b1, tag);
  endtask

  // Present a command in an idle cycle; it is accepted at the following edge.
  task automatic issue(input logic [1:0] m, input logic [31:0] on, input logic [31:0] off,
                       input logic [7:0] reps, input logic edone, input string tag);
    quiet();
    s_valid = 1'b1;
    s_mask  = m;
    s_on    = on;
    s_off   = off;
    s_reps  = reps;
    tick(2'b00, 1'b0, edone, 1'b1, tag);
  endtask

  task automatic scen2(input string tag);
    issue(2'b11, 32'd3, 32'd2, 8'd2, 1'b0, tag);
    run(2'b11, 3, tag);
    run(2'b00, 2, tag);
    run(2'b11, 3, tag);
    run(2'b00, 2, tag);
    idle(1'b1, tag);
    idle(1'b0, tag);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_mask  = 2'b00;
    cmd_on    = 32'd0;
    cmd_off   = 32'd0;
    cmd_reps  = 8'd0;
    abort     = 1'b0;

    // 1: reset held for three cycles, then released
    quiet();
    s_rst = 1'b1;
    repeat (3) tick(2'b00, 1'b0, 1'b0, 1'b1, "reset");
    idle(1'b0, "reset_release");

    // 2: two periods of 3 on / 2 off
    scen2("basic_2x");

    // 3: zero lengths act as one cycle
    issue(2'b01, 32'd0, 32'd0, 8'd1, 1'b0, "zero_len");
    run(2'b01, 1, "zero_len_on");
    run(2'b00, 1, "zero_len_off");
    idle(1'b1, "zero_len_done");
    idle(1'b0, "zero_len_after");

    // 4a: continuous sequence aborted in its 7th busy cycle
    issue(2'b10, 32'd2, 32'd2, 8'd0, 1'b0, "cont_a");
    run(2'b10, 2, "cont_a");
    run(2'b00, 2, "cont_a");
    run(2'b10, 2, "cont_a");
    quiet();
    s_abort = 1'b1;
    tick(2'b00, 1'b1, 1'b0, 1'b0, "cont_a_abort");
    idle(1'b0, "cont_a_stopped");

    // 4b: continuous sequence runs four full periods, then aborted while ON
    issue(2'b10, 32'd2, 32'd2, 8'd0, 1'b0, "cont_b");
    for (int p = 0; p < 4; p++) begin
      run(2'b10, 2, "cont_b_on");
      run(2'b00, 2, "cont_b_off");
    end
    quiet();
    s_abort = 1'b1;
    tick(2'b10, 1'b1, 1'b0, 1'b0, "cont_b_abort");
    idle(1'b0, "cont_b_stopped");

    // abort in IDLE blocks acceptance of a valid command
    quiet();
    s_valid = 1'b1;
    s_mask  = 2'b11;
    s_on    = 32'd1;
    s_off   = 32'd1;
    s_reps  = 8'd1;
    s_abort = 1'b1;
    tick(2'b00, 1'b0, 1'b0, 1'b0, "idle_abort_block");
    idle(1'b0, "idle_abort_not_taken");

    // 5: command held during busy is taken in the done cycle; held command
    //    differs from the running one, so live cmd_on must be ignored
    issue(2'b01, 32'd1, 32'd1, 8'd1, 1'b0, "hold_first");
    quiet();
    s_valid = 1'b1;
    s_mask  = 2'b10;
    s_on    = 32'd2;
    s_off   = 32'd1;
    s_reps  = 8'd1;
    tick(2'b01, 1'b1, 1'b0, 1'b0, "hold_busy_on");
    tick(2'b00, 1'b1, 1'b0, 1'b0, "hold_busy_off");
    tick(2'b00, 1'b0, 1'b1, 1'b1, "hold_done_accept");
    run(2'b10, 2, "hold_second_on");
    run(2'b00, 1, "hold_second_off");
    idle(1'b1, "hold_second_done");
    idle(1'b0, "hold_after");

    // full-scale ON length runs without early exit, then aborted
    issue(2'b01, 32'hFFFF_FFFF, 32'd1, 8'd1, 1'b0, "full_scale");
    run(2'b01, 5, "full_scale_on");
    quiet();
    s_abort = 1'b1;
    tick(2'b01, 1'b1, 1'b0, 1'b0, "full_scale_abort");
    idle(1'b0, "full_scale_stopped");

    // 6: reset during ON, then a fresh command behaves normally
    issue(2'b11, 32'd4, 32'd2, 8'd5, 1'b0, "mid_rst");
    run(2'b11, 2, "mid_rst_on");
    quiet();
    s_rst = 1'b1;
    tick(2'b11, 1'b1, 1'b0, 1'b0, "mid_rst_assert");
    idle(1'b0, "mid_rst_cleared");
    scen2("after_rst_2x");

    // Let the monitor consume the final entry.
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
